// File: rtl/pwm_serializer.sv
// pwm_serializer: turns a 0..100 % duty command into a fixed-frequency PWM
// waveform. Commands arrive over valid/ready into a one-deep shadow register
// and are applied only at period boundaries, so no period is ever truncated.
//
// Optional feature macro: PWM_RAMP_EN. When defined, the shadow value loads a
// target register and active_duty slews toward it by at most RAMP_STEP per
// period. When undefined, active_duty loads straight from the shadow register.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        asynchronous, active-high reset
//   enable       level-sensitive run request
//   duty_in      commanded duty in percent (values > 100 clamp to 100)
//   duty_valid   duty_in valid this cycle
//   duty_ready   shadow register empty, a command can be accepted
//   signal       registered PWM waveform
//   period_start one-cycle pulse in the first cycle of every period
//   active_duty  duty currently being generated
//   busy         state machine is not IDLE
module pwm_serializer #(
  parameter int WAVE_FREQ  = 10,
  parameter int PULSE_FREQ = 1000,
  parameter int SYS_FREQ   = 100000,
  parameter int RAMP_STEP  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  output logic       signal,
  output logic       period_start,
  output logic [6:0] active_duty,
  output logic       busy
);

  localparam int unsigned WAVE_WINDOW = SYS_FREQ / WAVE_FREQ;
  localparam int unsigned SLICE       = WAVE_WINDOW / 100;
  localparam int unsigned CW          = $clog2(WAVE_WINDOW) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Reject configurations where a period cannot be split into whole percent
  // slices; PULSE_FREQ only rides along for deserializer compatibility.
  if ((WAVE_WINDOW % 100) != 0 || WAVE_WINDOW < 100 || PULSE_FREQ < 0 ||
      RAMP_STEP < 0) begin : g_bad_cfg
    $error("pwm_serializer: SYS_FREQ/WAVE_FREQ must be a non-zero multiple of 100");
  end

  localparam logic [CW-1:0] LAST = CW'(WAVE_WINDOW - 1);

  logic [1:0]    state, state_n;
  logic [CW-1:0] counter, counter_n;
  logic [6:0]    shadow, shadow_n;
  logic [6:0]    active_n;
  logic          ready_n;
  logic          signal_n;
  logic          boundary_n;
  logic          busy_n;
  logic [6:0]    duty_clamped;
  logic          accept;
  logic          transfer;

`ifdef PWM_RAMP_EN
  logic [6:0] target, target_n;
  logic [6:0] ramp_diff;
  logic [6:0] ramp_amt;
  localparam logic [6:0] STEP = 7'(RAMP_STEP);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    counter_n = counter;
    shadow_n  = shadow;
    active_n  = active_duty;
    ready_n   = duty_ready;
`ifdef PWM_RAMP_EN
    target_n  = target;
    ramp_diff = 7'd0;
    ramp_amt  = 7'd0;
`endif

    case (state)
      IDLE: begin
        counter_n = '0;
        if (enable) state_n = RUN;
      end
      RUN: begin
        counter_n = (counter == LAST) ? '0 : counter + CW'(1);
        // Dropping enable in the last cycle already completes the period.
        if (!enable) state_n = (counter == LAST) ? IDLE : DRAIN;
      end
      DRAIN: begin
        counter_n = (counter == LAST) ? '0 : counter + CW'(1);
        if (enable)               state_n = RUN;
        else if (counter == LAST) state_n = IDLE;
      end
      default: begin
        state_n   = IDLE;
        counter_n = '0;
      end
    endcase

    // Boundary is the first RUN cycle of a period; decided here so the new
    // duty, the pulse and the waveform all line up in that cycle.
    boundary_n   = (state_n == RUN) && (counter_n == '0);
    duty_clamped = (duty_in > 7'd100) ? 7'd100 : duty_in;
    accept       = duty_valid && duty_ready;
    transfer     = boundary_n && !duty_ready;

    if (transfer) begin
      ready_n = 1'b1;
`ifdef PWM_RAMP_EN
      target_n = shadow;
`else
      active_n = shadow;
`endif
    end

`ifdef PWM_RAMP_EN
    // Slew toward the target by at most STEP per boundary.
    if (boundary_n) begin
      if (target_n > active_duty) begin
        ramp_diff = target_n - active_duty;
        ramp_amt  = (ramp_diff > STEP) ? STEP : ramp_diff;
        active_n  = active_duty + ramp_amt;
      end else begin
        ramp_diff = active_duty - target_n;
        ramp_amt  = (ramp_diff > STEP) ? STEP : ramp_diff;
        active_n  = active_duty - ramp_amt;
      end
    end
`endif

    // accept and transfer are exclusive: one needs ready high, the other low.
    if (accept) begin
      shadow_n = duty_clamped;
      ready_n  = 1'b0;
    end

    busy_n   = (state_n != IDLE);
    signal_n = busy_n && (counter_n < (CW'(active_n) * CW'(SLICE)));
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      shadow       <= 7'd0;
      duty_ready   <= 1'b1;
      active_duty  <= 7'd0;
      signal       <= 1'b0;
      period_start <= 1'b0;
      busy         <= 1'b0;
`ifdef PWM_RAMP_EN
      target       <= 7'd0;
`endif
    end else begin
      state        <= state_n;
      counter      <= counter_n;
      shadow       <= shadow_n;
      duty_ready   <= ready_n;
      active_duty  <= active_n;
      signal       <= signal_n;
      period_start <= boundary_n;
      busy         <= busy_n;
`ifdef PWM_RAMP_EN
      target       <= target_n;
`endif
    end
  end

endmodule

// File: doc/pwm_serializer.md
Name: pwm_serializer

Overview:
- PWM generator: converts a 7-bit duty-cycle command (0–100 %) into a fixed-frequency PWM waveform on `signal`.
- Sits directly upstream of the PWM deserializer and drives its `signal` input.
- Timing parameters are shared with the deserializer, so a loopback returns the commanded duty.
- Commands enter through a valid/ready handshake into a shadow register and take effect only at period boundaries, so output periods are never truncated.

Parameters:
- WAVE_FREQ, 10: PWM period rate in Hz.
- PULSE_FREQ, 1000: carried for parameter-list compatibility with the deserializer; unused.
- SYS_FREQ, 100000: clk frequency in Hz.
- RAMP_STEP, 5: maximum duty change (percent) per period; used only with PWM_RAMP_EN.
- Derived WAVE_WINDOW = SYS_FREQ/WAVE_FREQ (default 10000). Must be a multiple of 100; elaboration error otherwise.
- Derived SLICE = WAVE_WINDOW/100 (default 100): clk cycles per duty percent.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run request; level-sensitive.
- duty_in  input  7  commanded duty in percent.
- duty_valid  input  1  duty_in valid this cycle.
- duty_ready  output  1  shadow register empty; a command can be accepted.
- signal  output  1  PWM waveform, registered.
- period_start  output  1  one-cycle pulse in the first cycle of every period.
- active_duty  output  7  duty currently being generated.
- busy  output  1  state != IDLE.

Behaviour:
- Reset values (asynchronous): state IDLE, counter 0, signal 0, period_start 0, active_duty 0, shadow empty, duty_ready 1, busy 0.
- Handshake:
  - Accept on the posedge where duty_valid && duty_ready.
  - duty_in values > 100 are clamped to 100 on accept.
  - Accepted value goes into the shadow register; shadow full forces duty_ready = 0.
  - duty_valid while duty_ready = 0 is ignored; no stall, no overwrite.
- Counter: 0..WAVE_WINDOW-1 in RUN/DRAIN, wraps to 0. Width $clog2(WAVE_WINDOW)+1.
- Boundary: the cycle in which counter == 0 in RUN.
  - period_start = 1 in that cycle.
  - If the shadow register is full, active_duty takes the shadow value on that edge and the shadow empties. duty_ready = 1 the next cycle.
  - A command accepted in the boundary cycle itself is applied at the following boundary.
- Output: signal = 1 exactly while counter < active_duty*SLICE, using the active_duty in effect for that period.
  - Duty 0: signal held low for the whole period.
  - Duty 100: signal held high for the whole period, including across the wrap; no glitch at the boundary.
- State machine:
  - IDLE: signal 0, counter held at 0. enable = 1 → RUN. The first RUN cycle is a boundary (counter 0, period_start pulses, shadow applied).
  - RUN: enable = 0 → DRAIN. Counter continues.
  - DRAIN: finish the current period. At counter == WAVE_WINDOW-1 → IDLE; signal is 0 from the next cycle.
    - enable = 1 again during DRAIN → back to RUN with no break in the period.
    - No shadow transfer happens in DRAIN or IDLE.
  - Handshake stays active in every state. active_duty is retained through IDLE.
- Latency: command accepted in cycle t while RUN is applied at the next counter wrap; worst case WAVE_WINDOW cycles.
- Reset mid-period: everything returns to reset values immediately; any pending shadow command is lost.

Optional Feature:
- Macro: PWM_RAMP_EN.
- Defined:
  - At each boundary, active_duty moves toward a target register by min(RAMP_STEP, |target - active|).
  - The shadow value loads the target rather than active_duty.
  - Each period's output stays glitch-free.
- Undefined: active_duty loads directly from the shadow register; RAMP_STEP is ignored.

Test Plan:
- Reset, enable = 1, accept duty 30 → from the second period (first after accept), signal high for 3000 cycles then low for 7000; period_start every 10000 cycles.
- Accept duty 0, then duty 100 → one full period at constant 0, then constant 1 with no low cycle at the wrap.
- Accept duty 120 → clamped: active_duty = 100.
- Accept 40, present 70 while the shadow is full → 70 ignored (duty_ready = 0); active_duty becomes 40 at the next boundary; duty_ready returns 1 the cycle after.
- Drop enable at counter 2000 with duty 50 → waveform completes: high to 4999, low to 9999; busy = 0 and signal = 0 from counter wrap; period_start does not pulse.
- With PWM_RAMP_EN, active 20, accept 37 → active_duty 25, 30, 35, 37 on four consecutive boundaries.
- Reset mid-period → all outputs at reset values on the same edge.
